weights_fetch_ctrl: RTL and testbench

Sequencer that owns the read port of weights_memory. On a start command it walks a contiguous address window and drives address/en_read. It captures the memory's registered, Z-when-idle output into a 2-entry buffer and presents the weights to the neuron datapath as a valid/ready stream with a last marker. It sits between the top-level control FSM and the weights memory, and is the only driver of that memory's address/en_read.

---
 rtl/weights_fetch_ctrl_if.sv | 27 ++
 rtl/weights_fetch_ctrl.sv | 111 +++++++++++
 tb/tb_weights_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/weights_fetch_ctrl_if.sv
// weights_fetch_ctrl_if: memory read port and weight stream of the fetch sequencer.
//   mem_address/mem_en_read : sequencer -> weights_memory
//   mem_data                : weights_memory -> sequencer, valid one cycle after mem_en_read
//   weight_data/valid/last  : sequencer -> neuron datapath
//   weight_ready            : neuron datapath -> sequencer
interface weights_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 5,
    parameter int Addr_Depth = 12
);
    logic [Addr_Depth-1:0] mem_address;
    logic                  mem_en_read;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] weight_data;
    logic                  weight_valid;
    logic                  weight_ready;
    logic                  weight_last;

    modport master (
        output mem_address, mem_en_read, weight_data, weight_valid, weight_last,
        input  mem_data, weight_ready
    );

    modport slave (
        input  mem_address, mem_en_read, weight_data, weight_valid, weight_last,
        output mem_data, weight_ready
    );
endinterface

// File: rtl/weights_fetch_ctrl.sv
// weights_fetch_ctrl: walks an address window of weights_memory and streams the words out.
//   clock, reset (async, active-low)
//   start, abort, base_addr, num_weights : command from the control FSM
//   bus (master)                         : memory read port and valid/ready weight stream
//   busy, done                           : status back to the control FSM
module weights_fetch_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int Addr_Depth = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [Addr_Depth-1:0] base_addr,
    input  logic [Addr_Depth:0]   num_weights,
    weights_fetch_ctrl_if.master  bus,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [Addr_Depth:0] one = {{Addr_Depth{1'b0}}, 1'b1};

    state_t                state;
    logic [Addr_Depth-1:0] base;
    logic [Addr_Depth:0]   num;
    logic [Addr_Depth:0]   issued;
    logic [Addr_Depth:0]   written;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  pop;
    logic                  issue;

    assign pop = bus.weight_valid && bus.weight_ready;

    // Occupancy at the next edge: the returning read lands while the head may leave.
    // Issuing against this value keeps reads back-to-back under full throughput
    // while never holding more than two words buffered or in flight.
    assign occ_next = occ + {1'b0, in_flight} - {1'b0, pop};
    assign issue    = state == FETCH && !abort && issued != num && !occ_next[1];

    assign bus.mem_en_read  = issue;
    assign bus.mem_address  = base + issued[Addr_Depth-1:0];
    assign bus.weight_valid = occ != 2'd0;
    assign bus.weight_data  = buf_data[rd_ptr];
    assign bus.weight_last  = buf_last[rd_ptr] && occ != 2'd0;
    assign busy             = state != IDLE;
    assign done             = state == DONE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base        <= '0;
            num         <= '0;
            issued      <= '0;
            written     <= '0;
            in_flight   <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= '0;
        end else if (abort && state != IDLE) begin
            // Flush; clearing in_flight drops the read whose data is still on the bus.
            state     <= IDLE;
            in_flight <= 1'b0;
            occ       <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            in_flight <= issue;
            occ       <= occ_next;
            if (issue)
                issued <= issued + one;
            // mem_data is sampled only in the cycle after an issue, never while undriven.
            if (in_flight) begin
                buf_data[wr_ptr] <= bus.mem_data;
                buf_last[wr_ptr] <= written == num - one;
                wr_ptr           <= !wr_ptr;
                written          <= written + one;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            case (state)
                IDLE:
                    if (start && !abort) begin
                        base    <= base_addr;
                        num     <= num_weights;
                        issued  <= '0;
                        written <= '0;
                        state   <= num_weights == '0 ? DONE : FETCH;
                    end
                FETCH:
                    if (issue && issued + one == num)
                        state <= DRAIN;
                // Nothing left to issue, so a sole buffered word with no read returning is the last.
                DRAIN:
                    if (pop && occ == 2'd1 && !in_flight)
                        state <= DONE;
                DONE:
                    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weights_fetch_ctrl.sv
// tb_weights_fetch_ctrl: scoreboard bench for weights_fetch_ctrl with a behavioural weights memory.
module tb_weights_fetch_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] num_weights = '0;
    logic        busy;
    logic        done;
    logic        watch = 1'b0;
    logic        rd_v = 1'b0;
    logic [11:0] rd_a = '0;
    logic [11:0] addr_q [$];
    logic [5:0]  exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          max_outst = 0;
    int          n;

    weights_fetch_ctrl_if #(.DATA_WIDTH(5), .Addr_Depth(12)) bus ();

    weights_fetch_ctrl #(.DATA_WIDTH(5), .Addr_Depth(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .num_weights (num_weights),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] mem_word(input logic [11:0] a);
        return a[4:0] + a[11:7] + 5'd1;
    endfunction

    // Registered memory; 5'h15 stands in for the undriven bus between reads.
    always @(posedge clock) begin
        rd_v <= bus.mem_en_read;
        rd_a <= bus.mem_address;
    end
    assign bus.mem_data = rd_v ? mem_word(rd_a) : 5'h15;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic want(input logic [11:0] a, input logic [4:0] d, input logic l);
        addr_q.push_back(a);
        exp_q.push_back({l, d});
    endtask

    task automatic do_start(input logic [11:0] b, input logic [12:0] w);
        base_addr   = b;
        num_weights = w;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        check("done_seen", int'(done), 1);
        tick();
        check("done_width", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic monitor();
        logic       held_v;
        logic [6:0] held;
        int         outst;
        held_v = 1'b0;
        held   = '0;
        outst  = 0;
        forever begin
            @(negedge clock);
            if (watch) begin
                if (bus.mem_en_read) begin
                    if (addr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mem_address: read of %h issued, no read required", bus.mem_address);
                    end else
                        check("mem_address", int'(bus.mem_address), int'(addr_q.pop_front()));
                end
                if (bus.weight_valid && bus.weight_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL weight: transfer of %h last %b, no transfer required",
                                 bus.weight_data, bus.weight_last);
                    end else
                        check("weight", int'({bus.weight_last, bus.weight_data}), int'(exp_q.pop_front()));
                end
                if (held_v)
                    check("stall_hold", int'({bus.weight_valid, bus.weight_last, bus.weight_data}), int'(held));
            end
            held_v = bus.weight_valid && !bus.weight_ready && !abort && reset;
            held   = {bus.weight_valid, bus.weight_last, bus.weight_data};
            if (!busy)
                outst = 0;
            else begin
                if (outst > max_outst)
                    max_outst = outst;
                outst = outst + int'(bus.mem_en_read) - int'(bus.weight_valid && bus.weight_ready);
            end
        end
    endtask

    initial begin
        bus.weight_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_address", int'(bus.mem_address), 0);
        check("rst_mem_en_read", int'(bus.mem_en_read), 0);
        check("rst_weight_valid", int'(bus.weight_valid), 0);
        check("rst_weight_data", int'(bus.weight_data), 0);
        check("rst_weight_last", int'(bus.weight_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        tick();

        // Reset pulse in the middle of a fetch
        do_start(12'h100, 13'd8);
        tick();
        tick();
        check("fetch_busy", int'(busy), 1);
        #1 reset = 1'b0;
        #1;
        check("async_en_read", int'(bus.mem_en_read), 0);
        check("async_valid", int'(bus.weight_valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_address", int'(bus.mem_address), 0);
        check("async_data", int'(bus.weight_data), 0);
        reset = 1'b1;
        repeat (4) begin
            tick();
            check("post_rst_valid", int'(bus.weight_valid), 0);
            check("post_rst_busy", int'(busy), 0);
            check("post_rst_en_read", int'(bus.mem_en_read), 0);
        end
        watch = 1'b1;

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        base_addr = 12'h050;
        num_weights = 13'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        tick();
        check("abort_start_idle", int'(busy), 0);

        // Plain 4-word window with full throughput
        bus.weight_ready = 1'b1;
        want(12'h010, 5'h11, 1'b0);
        want(12'h011, 5'h12, 1'b0);
        want(12'h012, 5'h13, 1'b0);
        want(12'h013, 5'h14, 1'b1);
        do_start(12'h010, 13'd4);
        check("t2_first_en", int'(bus.mem_en_read), 1);
        check("t2_first_addr", int'(bus.mem_address), 'h010);
        tick();
        check("t2_valid_early", int'(bus.weight_valid), 0);
        tick();
        check("t2_valid_latency", int'(bus.weight_valid), 1);
        n = 2;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("t2_done_cycle", n, 6);
        tick();
        check("t2_done_width", int'(done), 0);

        // Window wrapping past the top of memory
        want(12'hFFE, 5'h1E, 1'b0);
        want(12'hFFF, 5'h1F, 1'b0);
        want(12'h000, 5'h01, 1'b0);
        want(12'h001, 5'h02, 1'b1);
        do_start(12'hFFE, 13'd4);
        wait_done(20);

        // Backpressure; a start while busy must be ignored
        want(12'h0A0, 5'h02, 1'b0);
        want(12'h0A1, 5'h03, 1'b0);
        want(12'h0A2, 5'h04, 1'b1);
        bus.weight_ready = 1'b0;
        do_start(12'h0A0, 13'd3);
        bus.weight_ready = 1'b1;
        tick();
        bus.weight_ready = 1'b0;
        base_addr = 12'h300;
        num_weights = 13'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bus.weight_ready = 1'b1;
        tick();
        bus.weight_ready = 1'b0;
        tick();
        bus.weight_ready = 1'b1;
        wait_done(20);

        // Empty window
        do_start(12'h123, 13'd0);
        check("t5_en_read", int'(bus.mem_en_read), 0);
        check("t5_busy", int'(busy), 1);
        check("t5_done", int'(done), 1);
        tick();
        check("t5_done_width", int'(done), 0);
        check("t5_busy_after", int'(busy), 0);

        // Abort after the second issue of a 6-word window, then a clean restart
        bus.weight_ready = 1'b0;
        addr_q.push_back(12'h040);
        addr_q.push_back(12'h041);
        do_start(12'h040, 13'd6);
        tick();
        tick();
        check("t6_valid_before_abort", int'(bus.weight_valid), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_valid_after_abort", int'(bus.weight_valid), 0);
        check("t6_en_after_abort", int'(bus.mem_en_read), 0);
        check("t6_busy_after_abort", int'(busy), 0);
        bus.weight_ready = 1'b1;
        repeat (4) begin
            check("t6_no_done", int'(done), 0);
            check("t6_no_valid", int'(bus.weight_valid), 0);
            tick();
        end
        want(12'h020, 5'h01, 1'b0);
        want(12'h021, 5'h02, 1'b1);
        do_start(12'h020, 13'd2);
        wait_done(20);

        repeat (3) tick();
        check("addr_queue_empty", addr_q.size(), 0);
        check("weight_queue_empty", exp_q.size(), 0);
        check("outstanding_le_2", int'(max_outst <= 2), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
